// File: rtl/pipe_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC selects, the NOP word
// and the fetch FSM states.
package pipe_pkg;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_JMP = 2'b11;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HELD  = 1'b1
  } if_state_e;

endpackage

// File: rtl/mux4x32.sv
// 4-way 32-bit selector used for next-PC choice (pc+4, branch, jr, jump).
module mux4x32
  import pipe_pkg::*;
(
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [1:0]  sel,
  output logic [31:0] y
);

  always_comb begin
    y = a0;
    case (sel)
      PCSRC_PC4: y = a0;
      PCSRC_BR:  y = a1;
      PCSRC_JR:  y = a2;
      PCSRC_JMP: y = a3;
      default:   y = a0;
    endcase
  end

endmodule

// File: rtl/pipeif.sv
// Instruction-fetch stage: PC, fetch handshake FSM, stall buffer, pending
// redirect target and the IF/ID pipeline register.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_FETCH | request outstanding at pc; waiting for imem_ready
// ST_HELD  | word for pc already fetched and parked in buf_word (ID stalled)
module pipeif
  import pipe_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);

  if_state_e   state;
  logic [31:0] buf_word;
  logic [31:0] tgt;
  logic        tgt_pend;

  logic [31:0] pc4;
  logic [31:0] sel_target;
  logic [31:0] tgt_aligned;
  logic [31:0] word;
  logic        redirect;
  logic        fetch_done;
  logic        deliver;

  assign pc4 = pc + 32'd4;

  mux4x32 u_npc_mux (
    .a0  (pc4),
    .a1  (bpc),
    .a2  (da),
    .a3  (jpc),
    .sel (pcsource),
    .y   (sel_target)
  );

  assign tgt_aligned = sel_target & 32'hFFFF_FFFC;
  assign redirect    = !wpcir && dvalid && (pcsource != PCSRC_PC4);
  assign fetch_done  = (state == ST_FETCH) && imem_ready;
  assign deliver     = !wpcir && (fetch_done || (state == ST_HELD));
  assign word        = (state == ST_HELD) ? buf_word : imem_rdata;

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_FETCH;
      pc       <= 32'h0;
      inst     <= NOP_WORD;
      dpc4     <= 32'h0;
      dvalid   <= 1'b0;
      buf_word <= 32'h0;
      tgt      <= 32'h0;
      tgt_pend <= 1'b0;
    end else if (deliver) begin
      inst   <= word;
      dpc4   <= pc4;
      dvalid <= 1'b1;
      state  <= ST_FETCH;
      // A live redirect wins; a parked target only exists while ID holds a bubble.
      if (redirect) begin
        pc <= tgt_aligned;
      end else if (tgt_pend) begin
        pc       <= tgt;
        tgt_pend <= 1'b0;
      end else begin
        pc <= pc4;
      end
    end else if (!wpcir) begin
      inst   <= NOP_WORD;
      dvalid <= 1'b0;
      if (redirect) begin
        tgt      <= tgt_aligned;
        tgt_pend <= 1'b1;
      end
    end else if (fetch_done) begin
      buf_word <= imem_rdata;
      state    <= ST_HELD;
    end
  end

endmodule

// File: tb/tb_pipeif.sv
// Randomized and directed bench for the fetch stage against a cycle-level
// model of the delivery / bubble / stall / redirect rules.
module tb_pipeif;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = 32'h0, jpc = 32'h0, da = 32'h0;
  logic        wpcir = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc, dpc4, inst;
  logic        dvalid;

  int n_checks = 0;
  int n_pass   = 0;

  pipeif dut (
    .clock      (clock),
    .reset      (reset),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .da         (da),
    .wpcir      (wpcir),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .dpc4       (dpc4),
    .inst       (inst),
    .dvalid     (dvalid)
  );

  always #5 clock = ~clock;

  // Reference model: the word for m_pc is either still in memory or parked locally.
  logic [31:0] m_pc, m_inst, m_dpc4, m_parked_word, m_jump_addr;
  logic        m_dvalid, m_parked, m_jump_pend;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_pc = 0; m_inst = 0; m_dpc4 = 0; m_dvalid = 0;
    m_parked = 0; m_parked_word = 0; m_jump_pend = 0; m_jump_addr = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".addr"}, imem_addr, m_pc);
    chk({tag, ".req"}, 32'(imem_req), 32'(!m_parked));
    chk({tag, ".inst"}, inst, m_inst);
    chk({tag, ".dpc4"}, dpc4, m_dpc4);
    chk({tag, ".dvalid"}, 32'(dvalid), 32'(m_dvalid));
  endtask

  task automatic step(input logic r, input logic w, input logic [1:0] ps,
                      input logic [31:0] b, input logic [31:0] j, input logic [31:0] d,
                      input string tag);
    logic [31:0] target, word;
    logic        have_word, id_jumps;
    imem_ready = r; wpcir = w; pcsource = ps; bpc = b; jpc = j; da = d;
    imem_rdata = (!m_parked && r) ? mem(m_pc) : $urandom;
    case (ps)
      2'b00:   target = m_pc + 4;
      2'b01:   target = b;
      2'b10:   target = d;
      default: target = j;
    endcase
    target    = {target[31:2], 2'b00};
    have_word = m_parked || r;
    word      = m_parked ? m_parked_word : mem(m_pc);
    id_jumps  = !w && m_dvalid && ps != 2'b00;
    @(posedge clock);
    #1;
    if (!w && have_word) begin
      m_inst = word; m_dpc4 = m_pc + 4; m_dvalid = 1; m_parked = 0;
      if (id_jumps) m_pc = target;
      else if (m_jump_pend) begin m_pc = m_jump_addr; m_jump_pend = 0; end
      else m_pc = m_pc + 4;
    end else if (!w) begin
      m_inst = 0; m_dvalid = 0;
      if (id_jumps) begin m_jump_addr = target; m_jump_pend = 1; end
    end else if (!m_parked && r) begin
      m_parked = 1; m_parked_word = word;
    end
    check_all(tag);
    @(negedge clock);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_all({tag, ".post"});
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 2'b00, 0, 0, 0, "stream");
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    check_all("reset");
    reset = 1'b0;
    #1;
    chk("reset.addr0", imem_addr, 32'h0);
    chk("reset.req1", 32'(imem_req), 32'd1);

    // zero-wait stream, then beq at 0x10 in ID
    stream(5);
    chk("str.dpc4", dpc4, 32'h14);
    chk("str.inst", inst, mem(32'h10));
    step(1, 0, 2'b01, 32'h40, 0, 0, "beq");
    chk("beq.slot", inst, mem(32'h14));
    chk("beq.next", imem_addr, 32'h40);

    // jump at 0x20 with 3 wait cycles on the delay-slot fetch
    pulse_reset("rst1");
    stream(9);
    chk("j.dpc4", dpc4, 32'h24);
    step(0, 0, 2'b11, 0, 32'h100, 0, "j.w1");
    chk("j.bub1", 32'(dvalid), 32'd0);
    step(0, 0, 2'b00, 0, 0, 0, "j.w2");
    step(0, 0, 2'b00, 0, 0, 0, "j.w3");
    chk("j.bub3", 32'(dvalid), 32'd0);
    chk("j.hold", pc, 32'h24);
    step(1, 0, 2'b00, 0, 0, 0, "j.dly");
    chk("j.slot", inst, mem(32'h24));
    chk("j.tgt", imem_addr, 32'h100);

    // stall with word ready: HELD, frozen, no refetch
    step(1, 1, 2'b00, 0, 0, 0, "stall1");
    chk("stall.req0", 32'(imem_req), 32'd0);
    step(1, 1, 2'b00, 0, 0, 0, "stall2");
    chk("stall.frz", inst, mem(32'h24));
    step(1, 0, 2'b00, 0, 0, 0, "stall.rel");
    chk("stall.word", inst, mem(32'h100));
    chk("stall.pc", pc, 32'h104);

    // wrap: jump to 0xFFFFFFFF (low bits dropped), then pc+4 wraps to 0
    step(1, 0, 2'b11, 0, 32'hFFFF_FFFF, 0, "wrap.j");
    chk("wrap.top", pc, 32'hFFFF_FFFC);
    step(1, 0, 2'b00, 0, 0, 0, "wrap.dly");
    chk("wrap.zero", pc, 32'h0);
    chk("wrap.dpc4", dpc4, 32'h0);

    // reset mid-wait with a pending target
    step(0, 0, 2'b10, 0, 0, 32'h0000_0800, "mw.jr");
    step(0, 0, 2'b00, 0, 0, 0, "mw.wait");
    pulse_reset("rst2");
    step(1, 0, 2'b00, 0, 0, 0, "mw.first");
    chk("mw.pc4", pc, 32'h4);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic       r, w;
      logic [1:0] ps;
      r  = ($urandom_range(0, 9) < 7);
      w  = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 99) == 0) pulse_reset("rnd.rst");
      else step(r, w, ps, $urandom, $urandom, $urandom, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
